fish_sprite_fetch: RTL and testbench

Read-side client of the fish sprite SRAM in the VGA animation path. It maps the current VGA pixel coordinate to a sprite SRAM address and selects the animation frame and horizontal position. It aligns the registered SRAM read data with the pixel stream and composites the sprite over the background. It sits between the VGA sync generator / background SRAM and the RGB output register that drives the connector.

---
 rtl/fish_sprite_fetch_pkg.sv | 19 +
 rtl/fish_anim_ctrl.sv | 72 +++++++
 rtl/fish_sprite_fetch.sv | 113 +++++++++++
 tb/tb_fish_sprite_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fish_sprite_fetch_pkg.sv
// Shared VGA constants and pipeline types
// for the fish sprite read path.
package vga_params;

  localparam int VGA_H_ACT = 640;
  localparam int VGA_V_ACT = 480;
  localparam int VGA_RGB_W = 12;
  localparam logic [11:0] VGA_KEY = 12'h0F0;

  typedef struct packed {
    logic box;
    logic von;
  } pix_flags_t;

  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fish_anim_ctrl.sv
// Sprite position and animation frame counters,
// advanced once per screen frame.
module fish_anim_ctrl
  import vga_params::*;
#(
  parameter int H_ACT    = VGA_H_ACT,
  parameter int V_ACT    = VGA_V_ACT,
  parameter int N_FRAMES = 2,
  parameter int ANIM_DIV = 8,
  parameter int SPEED    = 1,
  localparam int FW      = bits_for(N_FRAMES),
  localparam int CW      = bits_for(ANIM_DIV)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pixel_tick,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  output logic [9:0]    fish_x,
  output logic [FW-1:0] frame_idx
);

  logic [9:0]    fish_x_q, fish_x_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          upd;
  logic [10:0]   sum;

  assign upd = pixel_tick
             & (pixel_x == 10'd0)
             & (pixel_y == 10'(V_ACT));
  assign sum = {1'b0, fish_x_q} + 11'(SPEED);

  // next position / counter on update event
  always_comb begin
    fish_x_d = fish_x_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    if (upd) begin
      if (sum >= 11'(H_ACT))
        fish_x_d = 10'(sum - 11'(H_ACT));
      else
        fish_x_d = sum[9:0];
      if (cnt_q == CW'(ANIM_DIV - 1)) begin
        cnt_d = '0;
        if (frame_q == FW'(N_FRAMES - 1))
          frame_d = '0;
        else
          frame_d = frame_q + FW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // state registers, synchronous clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fish_x_q <= '0;
      frame_q  <= '0;
      cnt_q    <= '0;
    end else begin
      fish_x_q <= fish_x_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fish_x    = fish_x_q;
  assign frame_idx = frame_q;

endmodule

// File: rtl/fish_sprite_fetch.sv
// Maps VGA coordinates to sprite SRAM addresses
// and composites sprite pixels over background.
module fish_sprite_fetch
  import vga_params::*;
#(
  parameter int H_ACT      = VGA_H_ACT,
  parameter int V_ACT      = VGA_V_ACT,
  parameter int FISH_W     = 64,
  parameter int FISH_H     = 32,
  parameter int FISH_Y     = 64,
  parameter int N_FRAMES   = 2,
  parameter int ANIM_DIV   = 8,
  parameter int SPEED      = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = VGA_RGB_W,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT =
    DATA_WIDTH'(VGA_KEY)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pixel_tick,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_en,
  output logic                  sram_we,
  input  logic [DATA_WIDTH-1:0] sram_data,
  input  logic [DATA_WIDTH-1:0] bg_rgb,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  localparam int FW      = bits_for(N_FRAMES);
  localparam int W_SHIFT = $clog2(FISH_W);
  localparam int F_SHIFT = $clog2(FISH_W * FISH_H);

  logic [9:0]    fish_x;
  logic [FW-1:0] frame_idx;

  fish_anim_ctrl #(
    .H_ACT    (H_ACT),
    .V_ACT    (V_ACT),
    .N_FRAMES (N_FRAMES),
    .ANIM_DIV (ANIM_DIV),
    .SPEED    (SPEED)
  ) u_anim (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (pixel_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .fish_x     (fish_x),
    .frame_idx  (frame_idx)
  );

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  pix_flags_t            f1_q, f1_d, f2_q;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;

  logic [10:0] x11, fx11, y11;
  logic        in_box;
  logic [31:0] a_frame, a_row, a_col, a_sum;

  assign x11  = {1'b0, pixel_x};
  assign fx11 = {1'b0, fish_x};
  assign y11  = {1'b0, pixel_y};

  // box test and linear sprite address
  always_comb begin
    in_box = video_on
           & (x11 >= fx11)
           & (x11 < fx11 + 11'(FISH_W))
           & (y11 >= 11'(FISH_Y))
           & (y11 < 11'(FISH_Y + FISH_H));
    a_frame = 32'(frame_idx) << F_SHIFT;
    a_row   = 32'(pixel_y - 10'(FISH_Y)) << W_SHIFT;
    a_col   = 32'(pixel_x - fish_x);
    a_sum   = a_frame + a_row + a_col;
    addr_d  = in_box ? a_sum[ADDR_WIDTH-1:0] : '0;
    f1_d.box = in_box;
    f1_d.von = video_on;
  end

  // keyed composite of sprite over background
  always_comb begin
    rgb_d = bg_rgb;
    if (!f2_q.von)
      rgb_d = '0;
    else if (f2_q.box && sram_data != TRANSPARENT)
      rgb_d = sram_data;
  end

  // pipeline registers, synchronous clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
      rgb_q  <= '0;
    end else begin
      addr_q <= addr_d;
      f1_q   <= f1_d;
      f2_q   <= f1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_en   = 1'b1;
  assign sram_we   = 1'b0;
  assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_fish_sprite_fetch.sv
// Directed bench for fish_sprite_fetch:
// address map, keying, animation, clipping.
module tb_fish_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic [15:0] sram_addr;
  logic        sram_en;
  logic        sram_we;
  logic [11:0] sram_data;
  logic [11:0] bg_rgb;
  logic [11:0] rgb_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fish_sprite_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (pixel_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_data  (sram_data),
    .bg_rgb     (bg_rgb),
    .rgb_out    (rgb_out)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pix(input int x, input int y,
                         input logic von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
  endtask

  task automatic updates(input int n);
    for (int i = 0; i < n; i++) begin
      set_pix(0, 480, 1'b0);
      pixel_tick = 1'b1;
      wait_clk(1);
      pixel_tick = 1'b0;
      wait_clk(3);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    pixel_tick = 1'b0;
    set_pix(5, 66, 1'b1);
    sram_data = 12'hF80;
    bg_rgb = 12'h123;
    wait_clk(5);
    checks++;
    if (rgb_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got=%h exp=000", rgb_out);
    end
    checks++;
    if (sram_addr !== 16'd0) begin
      errors++;
      $display("FAIL reset_addr got=%0d exp=0", sram_addr);
    end
    checks++;
    if (dut.fish_x !== 10'd0) begin
      errors++;
      $display("FAIL reset_fish_x got=%0d exp=0", dut.fish_x);
    end
    checks++;
    if (dut.frame_idx !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame got=%0d exp=0", dut.frame_idx);
    end
    checks++;
    if (sram_en !== 1'b1 || sram_we !== 1'b0) begin
      errors++;
      $display("FAIL sram_ctl got=%b%b exp=10", sram_en, sram_we);
    end
    set_pix(0, 0, 1'b0);
    reset_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_address_map;
    set_pix(5, 66, 1'b1);
    wait_clk(1);
    checks++;
    if (sram_addr !== 16'd133) begin
      errors++;
      $display("FAIL addr_f0 got=%0d exp=133", sram_addr);
    end
    set_pix(200, 66, 1'b1);
    wait_clk(1);
    checks++;
    if (sram_addr !== 16'd0) begin
      errors++;
      $display("FAIL addr_outbox got=%0d exp=0", sram_addr);
    end
    set_pix(63, 95, 1'b1);
    wait_clk(1);
    checks++;
    if (sram_addr !== 16'd2047) begin
      errors++;
      $display("FAIL addr_corner got=%0d exp=2047", sram_addr);
    end
  endtask

  task automatic test_transparency;
    sram_data = 12'h0F0;
    bg_rgb = 12'h123;
    set_pix(5, 66, 1'b1);
    wait_clk(3);
    checks++;
    if (rgb_out !== 12'h123) begin
      errors++;
      $display("FAIL key_bg got=%h exp=123", rgb_out);
    end
    set_pix(5, 66, 1'b0);
    wait_clk(4);
    sram_data = 12'hF80;
    set_pix(5, 66, 1'b1);
    wait_clk(2);
    checks++;
    if (rgb_out !== 12'h000) begin
      errors++;
      $display("FAIL latency_early got=%h exp=000", rgb_out);
    end
    wait_clk(1);
    checks++;
    if (rgb_out !== 12'hF80) begin
      errors++;
      $display("FAIL sprite_px got=%h exp=F80", rgb_out);
    end
    set_pix(300, 66, 1'b1);
    wait_clk(3);
    checks++;
    if (rgb_out !== 12'h123) begin
      errors++;
      $display("FAIL outbox_bg got=%h exp=123", rgb_out);
    end
  endtask

  task automatic test_blanking;
    sram_data = 12'hF80;
    bg_rgb = 12'h456;
    set_pix(5, 66, 1'b0);
    wait_clk(3);
    checks++;
    if (rgb_out !== 12'h000) begin
      errors++;
      $display("FAIL blank_rgb got=%h exp=000", rgb_out);
    end
    checks++;
    if (sram_addr !== 16'd0) begin
      errors++;
      $display("FAIL blank_addr got=%0d exp=0", sram_addr);
    end
  endtask

  task automatic test_animation;
    updates(8);
    checks++;
    if (dut.frame_idx !== 1'b1 || dut.fish_x !== 10'd8) begin
      errors++;
      $display("FAIL anim_8 got=f%0d x%0d exp=f1 x8",
               dut.frame_idx, dut.fish_x);
    end
    set_pix(13, 66, 1'b1);
    wait_clk(1);
    checks++;
    if (sram_addr !== 16'd2181) begin
      errors++;
      $display("FAIL addr_f1 got=%0d exp=2181", sram_addr);
    end
    updates(8);
    checks++;
    if (dut.frame_idx !== 1'b0 || dut.fish_x !== 10'd16) begin
      errors++;
      $display("FAIL anim_16 got=f%0d x%0d exp=f0 x16",
               dut.frame_idx, dut.fish_x);
    end
  endtask

  task automatic test_clip_wrap;
    updates(623);
    checks++;
    if (dut.fish_x !== 10'd639 || dut.frame_idx !== 1'b1) begin
      errors++;
      $display("FAIL pos_639 got=x%0d f%0d exp=x639 f1",
               dut.fish_x, dut.frame_idx);
    end
    set_pix(639, 70, 1'b1);
    wait_clk(1);
    checks++;
    if (sram_addr !== 16'd2432) begin
      errors++;
      $display("FAIL clip_edge_addr got=%0d exp=2432", sram_addr);
    end
    sram_data = 12'hF80;
    bg_rgb = 12'h123;
    wait_clk(2);
    checks++;
    if (rgb_out !== 12'hF80) begin
      errors++;
      $display("FAIL clip_edge_rgb got=%h exp=F80", rgb_out);
    end
    set_pix(5, 66, 1'b1);
    wait_clk(1);
    checks++;
    if (sram_addr !== 16'd0) begin
      errors++;
      $display("FAIL no_wrap_addr got=%0d exp=0", sram_addr);
    end
    wait_clk(2);
    checks++;
    if (rgb_out !== 12'h123) begin
      errors++;
      $display("FAIL no_wrap_rgb got=%h exp=123", rgb_out);
    end
    updates(1);
    checks++;
    if (dut.fish_x !== 10'd0 || dut.frame_idx !== 1'b0) begin
      errors++;
      $display("FAIL wrap_x got=x%0d f%0d exp=x0 f0",
               dut.fish_x, dut.frame_idx);
    end
  endtask

  task automatic test_reset_mid;
    updates(3);
    set_pix(10, 70, 1'b1);
    wait_clk(3);
    reset_n = 1'b0;
    wait_clk(1);
    checks++;
    if (dut.fish_x !== 10'd0 || rgb_out !== 12'h000 ||
        sram_addr !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got=x%0d rgb%h a%0d exp=0",
               dut.fish_x, rgb_out, sram_addr);
    end
    reset_n = 1'b1;
    updates(8);
    checks++;
    if (dut.frame_idx !== 1'b1 || dut.fish_x !== 10'd8) begin
      errors++;
      $display("FAIL post_reset got=f%0d x%0d exp=f1 x8",
               dut.frame_idx, dut.fish_x);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    pixel_tick = 1'b0;
    set_pix(0, 0, 1'b0);
    sram_data = '0;
    bg_rgb = '0;
    wait_clk(1);
    test_reset;
    test_address_map;
    test_transparency;
    test_blanking;
    test_animation;
    test_clip_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
